// File: rtl/mult_pkg.sv
// Shared constants and types for the unsigned array multiplier.
package mult_pkg;
  localparam int DEFAULT_WIDTH = 2;

  typedef logic [3:0] prod2_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/mult_full_adder.sv
// One-bit full adder cell of the multiplier array.
// Latency: combinational. Backpressure: none.
module mult_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/multiplier_2bit.sv
// Unsigned WIDTH x WIDTH array multiplier, registered product; MULT_PIPE_EN adds a mid-array stage.
// Latency: 1 cycle (2 cycles with MULT_PIPE_EN).
// Backpressure: none, a new operand pair is accepted every cycle.
module multiplier_2bit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PW    = prod_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [PW-1:0]    P,
  output logic             out_valid
);
  // acc[i] is the running sum after row i; bit 0 is product bit i, the rest shifts into row i+1
  logic [WIDTH:0]   acc [WIDTH];
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] a_late;
  logic [WIDTH-2:0] b_late;
  logic [WIDTH-1:0] split_sum;
  logic [WIDTH-1:0] acc_hi;
  logic             vld_late;
  logic [PW-1:0]    prod;

  assign acc[0] = {1'b0, A & {WIDTH{B[0]}}};

`ifdef MULT_PIPE_EN
  localparam int SPLIT = (WIDTH + 1) / 2;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      split_sum <= '0;
      lo_q      <= '0;
      a_late    <= '0;
      b_late    <= '0;
      vld_late  <= 1'b0;
    end else begin
      split_sum <= acc[SPLIT][WIDTH:1];
      lo_q      <= lo;
      a_late    <= A;
      b_late    <= B[WIDTH-1:1];
      vld_late  <= in_valid;
    end
  end

  // Product bits already settled before the split come from the stage register
  always_comb begin
    prod = {acc_hi, lo};
    for (int i = 0; i < WIDTH; i++) begin
      if (i <= SPLIT) prod[i] = lo_q[i];
    end
  end
`else
  localparam int SPLIT = 0;

  assign split_sum = acc[0][WIDTH:1];
  assign a_late    = A;
  assign b_late    = B[WIDTH-1:1];
  assign vld_late  = in_valid;
  assign prod      = {acc_hi, lo};
`endif

  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    if (i > SPLIT) begin : g_late
      assign pp = a_late & {WIDTH{b_late[i-1]}};
      if (i == SPLIT + 1) begin : g_first
        assign sum_in = split_sum;
      end else begin : g_next
        assign sum_in = acc[i-1][WIDTH:1];
      end
    end else begin : g_early
      assign pp     = A & {WIDTH{B[i]}};
      assign sum_in = acc[i-1][WIDTH:1];
    end

    assign c[0] = 1'b0;
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      mult_full_adder u_fa (
        .a   (sum_in[j]),
        .b   (pp[j]),
        .cin (c[j]),
        .s   (s[j]),
        .cout(c[j+1])
      );
    end
    assign acc[i] = {c[WIDTH], s};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lo
    assign lo[i] = acc[i][0];
  end

  if (SPLIT >= WIDTH - 1) begin : g_hi_split
    assign acc_hi = split_sum;
  end else begin : g_hi_live
    assign acc_hi = acc[WIDTH-1][WIDTH:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      P         <= prod;
      out_valid <= vld_late;
    end
  end
endmodule

// File: tb/tb_multiplier_2bit.sv
// Randomized and directed bench for multiplier_2bit at WIDTH=2 and WIDTH=8.
module tb_multiplier_2bit;
  import mult_pkg::*;

`ifdef MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        v2, ov2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;
  logic        v8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  always #5 clk = ~clk;

  multiplier_2bit #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .A(a2), .B(b2), .P(p2), .out_valid(ov2)
  );

  multiplier_2bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .P(p8), .out_valid(ov8)
  );

  // One entry per clock edge, newest first
  typedef struct {
    bit r;
    int prod;
    bit v;
  } smp_t;

  smp_t h2[$];
  smp_t h8[$];
  int   total = 0;
  int   bad   = 0;

  // Output after an edge: zero if reset was seen within the last LAT edges,
  // otherwise the operands/valid sampled LAT-1 edges earlier.
  function automatic int exp_p(input smp_t h[$]);
    for (int i = 0; i < LAT; i++) if (h[i].r) return 0;
    return h[LAT-1].prod;
  endfunction

  function automatic bit exp_v(input smp_t h[$]);
    for (int i = 0; i < LAT; i++) if (h[i].r) return 1'b0;
    return h[LAT-1].v;
  endfunction

  task automatic step(input bit r, input bit va, input int xa, input int xb,
                      input bit vb, input int ya, input int yb);
    rst = r;
    v2  = va;
    a2  = xa[1:0];
    b2  = xb[1:0];
    v8  = vb;
    a8  = ya[7:0];
    b8  = yb[7:0];
    @(posedge clk);
    h2.push_front('{r, xa * xb, va});
    h8.push_front('{r, ya * yb, vb});
    if (h2.size() > 4) begin
      void'(h2.pop_back());
      void'(h8.pop_back());
    end
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 3, 3, 1'b1, 255, 255);
      total++;
      if (p2 !== 4'd0 || ov2 !== 1'b0) begin
        bad++;
        $display("FAIL reset_w2 edge=%0d got P=%0d ov=%0b want P=0 ov=0", k, p2, ov2);
      end
      total++;
      if (p8 !== 16'd0 || ov8 !== 1'b0) begin
        bad++;
        $display("FAIL reset_w8 edge=%0d got P=%0d ov=%0b want P=0 ov=0", k, p8, ov8);
      end
    end
    for (int k = 0; k < LAT; k++) begin
      step(1'b0, 1'b1, 3, 3, 1'b0, 0, 0);
      total++;
      if (k < LAT - 1 && (p2 !== 4'd0 || ov2 !== 1'b0)) begin
        bad++;
        $display("FAIL reset_fill got P=%0d ov=%0b want P=0 ov=0", p2, ov2);
      end else if (k == LAT - 1 && (p2 !== 4'd9 || ov2 !== 1'b1)) begin
        bad++;
        $display("FAIL reset_release got P=%0d ov=%0b want P=9 ov=1", p2, ov2);
      end
    end
  endtask

  task automatic test_directed;
    int va[9] = '{1, 1, 2, 3, 1, 3, 2, 3, 2};
    int vb[9] = '{1, 3, 2, 3, 2, 2, 1, 1, 3};
    int ep[9] = '{1, 3, 4, 9, 2, 6, 2, 3, 6};
    for (int k = 0; k < 9 + LAT - 1; k++) begin
      int idx;
      idx = (k < 9) ? k : 8;
      step(1'b0, 1'b1, va[idx], vb[idx], 1'b0, 0, 0);
      if (k >= LAT - 1) begin
        total++;
        if (p2 !== 4'(ep[k-LAT+1]) || ov2 !== 1'b1) begin
          bad++;
          $display("FAIL directed vec=%0d got P=%0d ov=%0b want P=%0d ov=1",
                   k - LAT + 1, p2, ov2, ep[k-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_zero;
    int za[3] = '{0, 2, 0};
    int zb[3] = '{3, 0, 0};
    for (int k = 0; k < 3 + LAT - 1; k++) begin
      int idx;
      idx = (k < 3) ? k : 2;
      step(1'b0, 1'b1, za[idx], zb[idx], 1'b1, za[idx] * 85, zb[idx] * 85);
      if (k >= LAT - 1) begin
        total++;
        if (p2 !== 4'd0 || p8 !== 16'd0) begin
          bad++;
          $display("FAIL zero vec=%0d got P2=%0d P8=%0d want 0", k - LAT + 1, p2, p8);
        end
      end
    end
  endtask

  task automatic test_valid;
    bit pat[3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3 + LAT - 1; k++) begin
      bit vin;
      vin = (k < 3) ? pat[k] : 1'b1;
      step(1'b0, vin, 2, 3, 1'b0, 0, 0);
      if (k >= LAT - 1) begin
        total++;
        if (ov2 !== pat[k-LAT+1] || p2 !== 4'd6) begin
          bad++;
          $display("FAIL valid_track idx=%0d got P=%0d ov=%0b want P=6 ov=%0b",
                   k - LAT + 1, p2, ov2, pat[k-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b1, 1, 3, 1'b1, 17, 19);
    step(1'b1, 1'b1, 3, 3, 1'b1, 200, 200);
    total++;
    if (p2 !== 4'd0 || ov2 !== 1'b0 || p8 !== 16'd0 || ov8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got P2=%0d ov2=%0b P8=%0d ov8=%0b want all 0", p2, ov2, p8, ov8);
    end
    for (int k = 0; k < LAT; k++) begin
      step(1'b0, 1'b1, 2, 3, 1'b1, 12, 13);
      total++;
      if (k < LAT - 1 && (p2 !== 4'd0 || ov2 !== 1'b0)) begin
        bad++;
        $display("FAIL reset_mid_fill got P=%0d ov=%0b want P=0 ov=0", p2, ov2);
      end else if (k == LAT - 1 && (p2 !== 4'd6 || ov2 !== 1'b1 || p8 !== 16'd156)) begin
        bad++;
        $display("FAIL reset_mid_release got P2=%0d ov=%0b P8=%0d want P2=6 ov=1 P8=156",
                 p2, ov2, p8);
      end
    end
  endtask

  task automatic test_w8_corners;
    int ca[5] = '{255, 255, 0, 1, 128};
    int cb[5] = '{255, 0, 255, 255, 2};
    int ce[5] = '{65025, 0, 0, 255, 256};
    for (int k = 0; k < 5 + LAT - 1; k++) begin
      int idx;
      idx = (k < 5) ? k : 4;
      step(1'b0, 1'b0, 0, 0, 1'b1, ca[idx], cb[idx]);
      if (k >= LAT - 1) begin
        total++;
        if (p8 !== 16'(ce[k-LAT+1]) || ov8 !== 1'b1) begin
          bad++;
          $display("FAIL w8_corner idx=%0d got P=%0d ov=%0b want P=%0d ov=1",
                   k - LAT + 1, p8, ov8, ce[k-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      bit r;
      r = ($urandom_range(63) == 0);
      step(r, 1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)),
           1'($urandom_range(1)), int'($urandom_range(255)), int'($urandom_range(255)));
      total++;
      if (p2 !== 4'(exp_p(h2)) || ov2 !== exp_v(h2)) begin
        bad++;
        $display("FAIL random_w2 step=%0d got P=%0d ov=%0b want P=%0d ov=%0b",
                 k, p2, ov2, exp_p(h2), exp_v(h2));
      end
      total++;
      if (p8 !== 16'(exp_p(h8)) || ov8 !== exp_v(h8)) begin
        bad++;
        $display("FAIL random_w8 step=%0d got P=%0d ov=%0b want P=%0d ov=%0b",
                 k, p8, ov8, exp_p(h8), exp_v(h8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_valid();
    test_reset_mid();
    test_w8_corners();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
